// File: rtl/cmd_frame_gate.sv
// cmd_frame_gate: sync/length/idle-timeout framing gate in front of the command FIFO write port
module cmd_frame_gate #(
  parameter int              WIDTH       = 8,
  parameter int              MAX_LEN     = 15,
  parameter int              TOW         = 16,
  parameter int              TIMEOUT_CYC = 5000,
  parameter bit              SYNC_EN     = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_BYTE  = 8'hEB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             fifo_full,
  output logic             wen,
  output logic [WIDTH-1:0] din,
  output logic             cmdend,
  output logic             busy,
  output logic             trunc,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       drop_cnt
);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t           state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [TOW-1:0]   idle_q, idle_d;
  logic             wen_q, wen_d, cmdend_q, cmdend_d, trunc_q, trunc_d;
  logic             tseen_q, tseen_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [7:0]       frame_q, frame_d, drop_q, drop_d;
  logic             timeout, sync_ok;
  assign timeout = idle_q == TOW'(TIMEOUT_CYC - 1);
  assign sync_ok = !SYNC_EN || rx_data == SYNC_BYTE;
  // Next-state: a byte always beats the timeout; tseen limits trunc to one pulse per frame
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idle_d   = idle_q;
    wen_d    = 1'b0;
    din_d    = din_q;
    cmdend_d = 1'b0;
    trunc_d  = 1'b0;
    tseen_d  = tseen_q;
    frame_d  = frame_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        idle_d = '0;
        if (rx_valid && sync_ok && !fifo_full) begin
          wen_d   = 1'b1;
          din_d   = rx_data;
          len_d   = LW'(1);
          tseen_d = 1'b0;
          state_d = RECV;
        end else if (rx_valid) begin
          drop_d  = (&drop_q) ? drop_q : drop_q + 8'd1;
          state_d = DROP;
        end
      end
      RECV: begin
        if (rx_valid) begin
          idle_d = '0;
          if (len_q < LW'(MAX_LEN)) begin
            wen_d = 1'b1;
            din_d = rx_data;
            len_d = len_q + LW'(1);
          end else begin
            trunc_d = !tseen_q;
            tseen_d = 1'b1;
          end
        end else if (timeout) begin
          cmdend_d = 1'b1;
          frame_d  = frame_q + 8'd1;
          len_d    = '0;
          idle_d   = '0;
          state_d  = IDLE;
        end else begin
          idle_d = idle_q + TOW'(1);
        end
      end
      DROP: begin
        idle_d  = (rx_valid || timeout) ? '0 : idle_q + TOW'(1);
        state_d = (!rx_valid && timeout) ? IDLE : DROP;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs, cleared immediately by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      idle_q   <= '0;
      wen_q    <= 1'b0;
      din_q    <= '0;
      cmdend_q <= 1'b0;
      trunc_q  <= 1'b0;
      tseen_q  <= 1'b0;
      frame_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idle_q   <= idle_d;
      wen_q    <= wen_d;
      din_q    <= din_d;
      cmdend_q <= cmdend_d;
      trunc_q  <= trunc_d;
      tseen_q  <= tseen_d;
      frame_q  <= frame_d;
      drop_q   <= drop_d;
    end
  end
  assign wen       = wen_q;
  assign din       = din_q;
  assign cmdend    = cmdend_q;
  assign trunc     = trunc_q;
  assign busy      = state_q != IDLE;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_cmd_frame_gate.sv
// tb_cmd_frame_gate: directed self-checking bench for cmd_frame_gate
module tb_cmd_frame_gate;
  localparam int T = 8;
  logic       clk = 1'b0, rst_n = 1'b1, rx_valid = 1'b0, fifo_full = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wen, cmdend, busy, trunc;
  logic [7:0] din, frame_cnt, drop_cnt;
  int n_chk = 0, n_fail = 0, n_wen = 0, n_cmd = 0, n_trunc = 0, n_ovl = 0;
  cmd_frame_gate #(.WIDTH(8), .MAX_LEN(15), .TOW(16), .TIMEOUT_CYC(T), .SYNC_EN(1'b1), .SYNC_BYTE(8'hEB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .fifo_full(fifo_full),
    .wen(wen), .din(din), .cmdend(cmdend), .busy(busy), .trunc(trunc),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  // Pulse counters; reading at posedge sees the cycle that just ended
  always @(posedge clk) begin
    if (rst_n) begin
      if (wen) n_wen++;
      if (cmdend) n_cmd++;
      if (trunc) n_trunc++;
      if (wen && cmdend) n_ovl++;
    end
  end
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic wait_cmd(output int k);
    k = -1;
    for (int i = 1; i <= 40 && k < 0; i++) begin
      @(negedge clk);
      if (cmdend) k = i;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, w0, c0, t0;
    logic [7:0] f1 [4];
    f1 = '{8'hEB, 8'h01, 8'h02, 8'h03};
    #2 rst_n = 1'b0;
    #1;
    check("rst_wen", wen, 0);
    check("rst_din", din, 0);
    check("rst_cmdend", cmdend, 0);
    check("rst_busy", busy, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // basic 4-byte frame
    for (int i = 0; i < 4; i++) begin
      if (i != 0) idle(4);
      send(f1[i]);
      check("t1_wen", wen, 1);
      check("t1_din", din, f1[i]);
    end
    wait_cmd(k);
    check("t1_cmd_lat", k, T);
    idle(1);
    check("t1_cmd_pulse", cmdend, 0);
    check("t1_frame", frame_cnt, 1);
    check("t1_busy", busy, 0);
    // bad sync byte
    send(8'h55);
    check("t2_wen", wen, 0);
    check("t2_busy", busy, 1);
    check("t2_drop", drop_cnt, 1);
    c0 = n_cmd;
    idle(T + 2);
    check("t2_busy_end", busy, 0);
    check("t2_no_cmd", n_cmd - c0, 0);
    send(8'hEB);
    check("t2_new_wen", wen, 1);
    wait_cmd(k);
    check("t2_cmd_lat", k, T);
    check("t2_frame", frame_cnt, 2);
    // 20-byte frame against MAX_LEN 15
    idle(2);
    w0 = n_wen; t0 = n_trunc; c0 = n_cmd;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) idle(1);
      send(i == 0 ? 8'hEB : 8'(i));
      if (i == 14) check("t3_wen15", wen, 1);
      if (i == 15) check("t3_wen16", wen, 0);
      if (i == 15) check("t3_trunc16", trunc, 1);
      if (i == 16) check("t3_trunc17", trunc, 0);
    end
    wait_cmd(k);
    check("t3_cmd_lat", k, T);
    idle(2);
    check("t3_wen_cnt", n_wen - w0, 15);
    check("t3_trunc_cnt", n_trunc - t0, 1);
    check("t3_cmd_cnt", n_cmd - c0, 1);
    check("t3_frame", frame_cnt, 3);
    // fifo full at frame start, released mid-frame
    fifo_full = 1'b1;
    send(8'hEB);
    check("t4_wen", wen, 0);
    check("t4_drop", drop_cnt, 2);
    check("t4_busy", busy, 1);
    fifo_full = 1'b0;
    c0 = n_cmd; w0 = n_wen;
    idle(2);
    send(8'hEB);
    check("t4_wen_mid", wen, 0);
    idle(T + 2);
    check("t4_busy_end", busy, 0);
    check("t4_no_cmd", n_cmd - c0, 0);
    check("t4_no_wen", n_wen - w0, 0);
    check("t4_frame", frame_cnt, 3);
    // byte arriving on the last idle cycle before timeout
    send(8'hEB);
    c0 = n_cmd;
    idle(T - 1);
    send(8'h11);
    check("t5_wen", wen, 1);
    check("t5_din", din, 8'h11);
    check("t5_no_cmd", n_cmd - c0, 0);
    wait_cmd(k);
    check("t5_cmd_lat", k, T);
    check("t5_frame", frame_cnt, 4);
    // back-to-back frame right after cmdend
    send(8'hEB);
    check("t6_wen", wen, 1);
    check("t6_cmd_low", cmdend, 0);
    idle(4);
    send(8'h01);
    idle(4);
    send(8'h02);
    check("t6_wen3", wen, 1);
    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    check("t7_wen", wen, 0);
    check("t7_din", din, 0);
    check("t7_busy", busy, 0);
    check("t7_cmdend", cmdend, 0);
    check("t7_frame", frame_cnt, 0);
    check("t7_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hEB);
    check("t7_new_wen", wen, 1);
    check("t7_new_din", din, 8'hEB);
    wait_cmd(k);
    check("t7_cmd_lat", k, T);
    check("t7_frame_after", frame_cnt, 1);
    idle(2);
    check("overlap", n_ovl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
